// File: rtl/tl_ul_source_arbiter_pkg.sv
// Shared definitions for the two-client TileLink-UL source arbiter.
//   - TileLink opcodes that decide whether a message has more than one beat
//   - arbiter FSM state type
//   - num_beats(): beat count of a message from its size field
package tl_ul_arb_pkg;

    localparam logic [2:0] PUT_FULL = 3'd0;   // A: PutFullData
    localparam logic [2:0] PUT_PART = 3'd1;   // A: PutPartialData
    localparam logic [2:0] ACK_DATA = 3'd1;   // D: AccessAckData

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Number of beats of a data-carrying message of 2^size bytes on a
    // 2^beat_lg byte bus. Messages no wider than the bus take one beat.
    function automatic logic [7:0] num_beats(input logic [2:0] size, input logic [2:0] beat_lg);
        if (size > beat_lg)
            num_beats = 8'd1 << (size - beat_lg);
        else
            num_beats = 8'd1;
    endfunction

endpackage

// File: rtl/tl_ul_source_arbiter_if.sv
// One TileLink-UL A/D link.
//   master : drives A (valid + bits) and D ready; receives A ready and D (valid + bits)
//   slave  : the opposite side
// SRC_W is the source-id width (4 on the client side, 5 downstream).
interface tl_ul_source_arbiter_if #(parameter int SRC_W = 4);

    logic             a_ready;
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [2:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [31:0]      a_address;
    logic [7:0]       a_mask;
    logic [63:0]      a_data;
    logic             a_corrupt;

    logic             d_ready;
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [2:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic             d_denied;
    logic [63:0]      d_data;
    logic             d_corrupt;

    modport master (
        input  a_ready,
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output d_ready,
        input  d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt
    );

    modport slave (
        output a_ready,
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  d_ready,
        output d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt
    );

endinterface

// File: rtl/tl_ul_beat_counter.sv
// Beat tracker for one TileLink channel.
// Ports:
//   clock, reset (async, active-low)
//   fire          beat handshake on the channel
//   opcode, size  header of the message currently on the channel
//   first         current beat is the first of its message
//   last          current beat is the last of its message
// IS_D selects which opcodes carry multiple beats: Put* on A, AccessAckData on D.
module tl_ul_beat_counter
    import tl_ul_arb_pkg::*;
#(
    parameter int BEAT_LG = 3,
    parameter bit IS_D    = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fire,
    input  logic [2:0] opcode,
    input  logic [2:0] size,
    output logic       first,
    output logic       last
);

    logic [7:0] cnt;
    logic [7:0] beats;
    logic       burst_op;

    assign burst_op = IS_D ? (opcode == ACK_DATA)
                           : ((opcode == PUT_FULL) || (opcode == PUT_PART));
    assign beats    = num_beats(size, 3'(BEAT_LG));
    assign first    = (cnt == 8'd0);
    assign last     = !burst_op || (cnt == beats - 8'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= 8'd0;
        else if (fire)
            cnt <= last ? 8'd0 : cnt + 8'd1;
    end

endmodule

// File: rtl/tl_ul_source_arbiter.sv
// Two-client TileLink-UL arbiter onto one downstream A/D link.
// A is arbitrated round-robin with zero added latency; the grant is held while
// the downstream stalls and for the whole of a multi-beat Put. The downstream
// source is {client_idx, client_source}; D is steered back by source[4].
// Per-client in-flight counters stop a client issuing new messages at MAX_INFLIGHT.
// Ports:
//   clock, reset          single clock; async active-low reset
//   auto_in0, auto_in1    client links (slave side, 4-bit source)
//   auto_out              downstream link (master side, 5-bit source)
module tl_ul_source_arbiter
    import tl_ul_arb_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int BEAT_LG      = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    tl_ul_source_arbiter_if.slave  auto_in0,
    tl_ul_source_arbiter_if.slave  auto_in1,
    tl_ul_source_arbiter_if.master auto_out
);

    localparam logic [3:0] LIMIT = 4'(MAX_INFLIGHT);

    arb_state_t state, state_nxt;
    logic       lock_idx, lock_idx_nxt;
    logic       rr_ptr;
    logic [3:0] inflight0, inflight1;

    logic elig0, elig1, grant, grant_vld;
    logic a_fire, a_first, a_last;
    logic d_fire, d_first, d_last, d_dst;
    logic inc0, inc1, dec0, dec1;

    assign elig0 = auto_in0.a_valid && (inflight0 < LIMIT);
    assign elig1 = auto_in1.a_valid && (inflight1 < LIMIT);

    // While locked the owner keeps the grant regardless of its in-flight count.
    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (state == LOCKED) begin
            grant     = lock_idx;
            grant_vld = lock_idx ? auto_in1.a_valid : auto_in0.a_valid;
        end else if (elig0 && elig1) begin
            grant     = rr_ptr;
            grant_vld = 1'b1;
        end else if (elig1) begin
            grant     = 1'b1;
            grant_vld = 1'b1;
        end else if (elig0) begin
            grant_vld = 1'b1;
        end
    end

    assign auto_out.a_valid   = reset && grant_vld;
    assign auto_in0.a_ready   = reset && grant_vld && auto_out.a_ready && !grant;
    assign auto_in1.a_ready   = reset && grant_vld && auto_out.a_ready &&  grant;
    assign auto_out.a_opcode  = grant ? auto_in1.a_opcode  : auto_in0.a_opcode;
    assign auto_out.a_param   = grant ? auto_in1.a_param   : auto_in0.a_param;
    assign auto_out.a_size    = grant ? auto_in1.a_size    : auto_in0.a_size;
    assign auto_out.a_source  = {grant, (grant ? auto_in1.a_source : auto_in0.a_source)};
    assign auto_out.a_address = grant ? auto_in1.a_address : auto_in0.a_address;
    assign auto_out.a_mask    = grant ? auto_in1.a_mask    : auto_in0.a_mask;
    assign auto_out.a_data    = grant ? auto_in1.a_data    : auto_in0.a_data;
    assign auto_out.a_corrupt = grant ? auto_in1.a_corrupt : auto_in0.a_corrupt;

    assign a_fire = auto_out.a_valid && auto_out.a_ready;

    // D steering: purely combinational, selected by the client bit of the source.
    assign d_dst              = auto_out.d_source[4];
    assign auto_in0.d_valid   = reset && auto_out.d_valid && !d_dst;
    assign auto_in1.d_valid   = reset && auto_out.d_valid &&  d_dst;
    assign auto_out.d_ready   = reset && (d_dst ? auto_in1.d_ready : auto_in0.d_ready);
    assign auto_in0.d_opcode  = auto_out.d_opcode;
    assign auto_in1.d_opcode  = auto_out.d_opcode;
    assign auto_in0.d_size    = auto_out.d_size;
    assign auto_in1.d_size    = auto_out.d_size;
    assign auto_in0.d_source  = auto_out.d_source[3:0];
    assign auto_in1.d_source  = auto_out.d_source[3:0];
    assign auto_in0.d_denied  = auto_out.d_denied;
    assign auto_in1.d_denied  = auto_out.d_denied;
    assign auto_in0.d_data    = auto_out.d_data;
    assign auto_in1.d_data    = auto_out.d_data;
    assign auto_in0.d_corrupt = auto_out.d_corrupt;
    assign auto_in1.d_corrupt = auto_out.d_corrupt;

    assign d_fire = auto_out.d_valid && auto_out.d_ready;

    tl_ul_beat_counter #(.BEAT_LG(BEAT_LG), .IS_D(1'b0)) u_a_beats (
        .clock  (clock),
        .reset  (reset),
        .fire   (a_fire),
        .opcode (auto_out.a_opcode),
        .size   (auto_out.a_size),
        .first  (a_first),
        .last   (a_last)
    );

    tl_ul_beat_counter #(.BEAT_LG(BEAT_LG), .IS_D(1'b1)) u_d_beats (
        .clock  (clock),
        .reset  (reset),
        .fire   (d_fire),
        .opcode (auto_out.d_opcode),
        .size   (auto_out.d_size),
        .first  (d_first),
        .last   (d_last)
    );

    // A stalled first beat must keep its bits stable, and a multi-beat Put must
    // not be interleaved, so both cases pin the grant until the last beat fires.
    always_comb begin
        state_nxt    = state;
        lock_idx_nxt = lock_idx;
        case (state)
            IDLE: begin
                if (grant_vld && (!auto_out.a_ready || !a_last)) begin
                    state_nxt    = LOCKED;
                    lock_idx_nxt = grant;
                end
            end
            LOCKED: begin
                if (a_fire && a_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lock_idx <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rr_ptr <= 1'b0;
        else if (a_fire && a_last)
            rr_ptr <= !grant;
    end

    assign inc0 = a_fire && a_first && !grant;
    assign inc1 = a_fire && a_first &&  grant;
    assign dec0 = d_fire && d_last  && !d_dst;
    assign dec1 = d_fire && d_last  &&  d_dst;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight0 <= 4'd0;
            inflight1 <= 4'd0;
        end else begin
            if (inc0 && !dec0)      inflight0 <= inflight0 + 4'd1;
            else if (dec0 && !inc0) inflight0 <= inflight0 - 4'd1;
            if (inc1 && !dec1)      inflight1 <= inflight1 + 4'd1;
            else if (dec1 && !inc1) inflight1 <= inflight1 - 4'd1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(dec0 && !inc0 && inflight0 == 4'd0)) else $error("inflight0 decremented at zero");
            assert (!(dec1 && !inc1 && inflight1 == 4'd0)) else $error("inflight1 decremented at zero");
            assert (!(inc0 && !dec0 && inflight0 >= LIMIT)) else $error("inflight0 incremented at limit");
            assert (!(inc1 && !dec1 && inflight1 >= LIMIT)) else $error("inflight1 incremented at limit");
            assert (!(d_fire && d_first && ((d_dst ? inflight1 : inflight0) == 4'd0)))
                else $error("D response for a client with nothing outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_tl_ul_source_arbiter.sv
// Directed bench for tl_ul_source_arbiter (MAX_INFLIGHT=2, 64-bit bus).
module tb_tl_ul_source_arbiter;
    import tl_ul_arb_pkg::*;

    localparam logic [2:0] GET = 3'd4;
    localparam logic [2:0] ACK = 3'd0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    tl_ul_source_arbiter_if #(.SRC_W(4)) in0_if ();
    tl_ul_source_arbiter_if #(.SRC_W(4)) in1_if ();
    tl_ul_source_arbiter_if #(.SRC_W(5)) out_if ();

    tl_ul_source_arbiter #(.MAX_INFLIGHT(2), .BEAT_LG(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .auto_in0 (in0_if),
        .auto_in1 (in1_if),
        .auto_out (out_if)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive_a(input int k, input logic v, input logic [2:0] op, input logic [2:0] sz,
                           input logic [3:0] src, input logic [31:0] addr, input logic [63:0] data);
        if (k == 0) begin
            in0_if.a_valid = v;  in0_if.a_opcode = op; in0_if.a_param = 3'd0; in0_if.a_size = sz;
            in0_if.a_source = src; in0_if.a_address = addr; in0_if.a_mask = 8'hFF;
            in0_if.a_data = data; in0_if.a_corrupt = 1'b0;
        end else begin
            in1_if.a_valid = v;  in1_if.a_opcode = op; in1_if.a_param = 3'd0; in1_if.a_size = sz;
            in1_if.a_source = src; in1_if.a_address = addr; in1_if.a_mask = 8'hFF;
            in1_if.a_data = data; in1_if.a_corrupt = 1'b0;
        end
    endtask

    task automatic drive_d(input logic v, input logic [2:0] op, input logic [2:0] sz,
                           input logic [4:0] src, input logic [63:0] data);
        out_if.d_valid = v; out_if.d_opcode = op; out_if.d_size = sz; out_if.d_source = src;
        out_if.d_denied = 1'b0; out_if.d_data = data; out_if.d_corrupt = 1'b0;
    endtask

    task automatic clear_all;
        drive_a(0, 1'b0, GET, 3'd3, 4'd0, 32'd0, 64'd0);
        drive_a(1, 1'b0, GET, 3'd3, 4'd0, 32'd0, 64'd0);
        drive_d(1'b0, ACK, 3'd3, 5'd0, 64'd0);
        out_if.a_ready = 1'b1;
        in0_if.d_ready = 1'b1;
        in1_if.d_ready = 1'b1;
    endtask

    task automatic do_reset;
        clear_all;
        reset = 1'b0;
        step;
        reset = 1'b1;
        step;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: outputs gated even with live inputs on every side.
        clear_all;
        drive_a(0, 1'b1, GET, 3'd3, 4'd5, 32'h40, 64'd0);
        drive_d(1'b1, ACK, 3'd3, 5'h00, 64'd0);
        settle;
        chk("rst_out_a_valid", 64'(out_if.a_valid), 64'd0);
        chk("rst_in0_a_ready", 64'(in0_if.a_ready), 64'd0);
        chk("rst_in0_d_valid", 64'(in0_if.d_valid), 64'd0);
        chk("rst_out_d_ready", 64'(out_if.d_ready), 64'd0);
        step;
        reset = 1'b1;
        clear_all;
        settle;
        chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        chk("rst_inflight0", 64'(dut.inflight0), 64'd0);
        chk("rst_state", 64'(dut.state), 64'd0);
        step;

        // 1: single Get from in0.
        drive_a(0, 1'b1, GET, 3'd3, 4'd5, 32'h1000_0040, 64'd0);
        settle;
        chk("t1_out_valid", 64'(out_if.a_valid), 64'd1);
        chk("t1_out_src", 64'(out_if.a_source), 64'h05);
        chk("t1_out_addr", 64'(out_if.a_address), 64'h1000_0040);
        chk("t1_in0_ready", 64'(in0_if.a_ready), 64'd1);
        chk("t1_in1_ready", 64'(in1_if.a_ready), 64'd0);
        step;
        drive_a(0, 1'b0, GET, 3'd3, 4'd5, 32'h1000_0040, 64'd0);
        settle;
        chk("t1_inflight0", 64'(dut.inflight0), 64'd1);
        chk("t1_rr_ptr", 64'(dut.rr_ptr), 64'd1);

        // 2: both requesting single-beat Gets alternate, then both hit the limit.
        do_reset;
        drive_a(0, 1'b1, GET, 3'd3, 4'd2, 32'h100, 64'd0);
        drive_a(1, 1'b1, GET, 3'd3, 4'd7, 32'h200, 64'd0);
        for (int i = 0; i < 4; i++) begin
            settle;
            chk($sformatf("t2_src_%0d", i), 64'(out_if.a_source), (i % 2 == 0) ? 64'h02 : 64'h17);
            chk($sformatf("t2_in0_rdy_%0d", i), 64'(in0_if.a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            step;
        end
        settle;
        chk("t2_both_limited", 64'(out_if.a_valid), 64'd0);

        // 3: 8-beat PutFull from in0 holds off in1 until it completes.
        do_reset;
        drive_a(1, 1'b1, GET, 3'd3, 4'd4, 32'h300, 64'd0);
        for (int b = 0; b < 8; b++) begin
            drive_a(0, 1'b1, PUT_FULL, 3'd6, 4'd1, 32'h400, 64'(b) + 64'hD0);
            settle;
            chk($sformatf("t3_in1_rdy_%0d", b), 64'(in1_if.a_ready), 64'd0);
            chk($sformatf("t3_data_%0d", b), out_if.a_data, 64'(b) + 64'hD0);
            step;
        end
        drive_a(0, 1'b0, PUT_FULL, 3'd6, 4'd1, 32'h400, 64'd0);
        settle;
        chk("t3_in1_rdy_9", 64'(in1_if.a_ready), 64'd1);
        chk("t3_src_9", 64'(out_if.a_source), 64'h14);
        chk("t3_rr_ptr", 64'(dut.rr_ptr), 64'd1);
        chk("t3_inflight0", 64'(dut.inflight0), 64'd1);
        step;

        // 4: stalled downstream keeps grant and bits on in0 though rr_ptr favours in1.
        do_reset;
        drive_a(0, 1'b1, GET, 3'd3, 4'd0, 32'h0, 64'd0);
        step;
        out_if.a_ready = 1'b0;
        drive_a(0, 1'b1, GET, 3'd3, 4'd3, 32'hABC0, 64'd0);
        settle;
        chk("t4_out_valid", 64'(out_if.a_valid), 64'd1);
        chk("t4_in0_rdy_stall", 64'(in0_if.a_ready), 64'd0);
        step;
        drive_a(1, 1'b1, GET, 3'd3, 4'd9, 32'h5550, 64'd0);
        for (int c = 0; c < 2; c++) begin
            settle;
            chk($sformatf("t4_src_%0d", c), 64'(out_if.a_source), 64'h03);
            chk($sformatf("t4_addr_%0d", c), 64'(out_if.a_address), 64'hABC0);
            chk($sformatf("t4_in1_rdy_%0d", c), 64'(in1_if.a_ready), 64'd0);
            step;
        end
        out_if.a_ready = 1'b1;
        settle;
        chk("t4_in0_fire", 64'(in0_if.a_ready), 64'd1);
        chk("t4_src_fire", 64'(out_if.a_source), 64'h03);
        step;
        drive_a(0, 1'b0, GET, 3'd3, 4'd3, 32'hABC0, 64'd0);
        settle;
        chk("t4_src_next", 64'(out_if.a_source), 64'h19);
        chk("t4_in1_rdy_next", 64'(in1_if.a_ready), 64'd1);
        step;

        // 5: third Get blocked at the limit, released by the D response.
        do_reset;
        drive_a(0, 1'b1, GET, 3'd3, 4'd1, 32'h10, 64'd0);
        step;
        drive_a(0, 1'b1, GET, 3'd3, 4'd2, 32'h20, 64'd0);
        step;
        drive_a(0, 1'b1, GET, 3'd3, 4'd3, 32'h30, 64'd0);
        settle;
        chk("t5_blocked_rdy", 64'(in0_if.a_ready), 64'd0);
        chk("t5_blocked_valid", 64'(out_if.a_valid), 64'd0);
        chk("t5_inflight_lim", 64'(dut.inflight0), 64'd2);
        drive_d(1'b1, ACK, 3'd3, 5'h00, 64'd0);
        settle;
        chk("t5_in0_d_valid", 64'(in0_if.d_valid), 64'd1);
        chk("t5_in1_d_valid", 64'(in1_if.d_valid), 64'd0);
        chk("t5_out_d_ready", 64'(out_if.d_ready), 64'd1);
        chk("t5_still_blocked", 64'(in0_if.a_ready), 64'd0);
        step;
        drive_d(1'b0, ACK, 3'd3, 5'h00, 64'd0);
        settle;
        chk("t5_unblocked", 64'(in0_if.a_ready), 64'd1);
        chk("t5_src", 64'(out_if.a_source), 64'h03);
        chk("t5_inflight_dec", 64'(dut.inflight0), 64'd1);
        step;
        drive_a(0, 1'b0, GET, 3'd3, 4'd3, 32'h30, 64'd0);
        settle;
        chk("t5_inflight_back", 64'(dut.inflight0), 64'd2);

        // 6: 2-beat AccessAckData to in1; decrement only on beat 2, cancelled by an A fire.
        do_reset;
        drive_a(1, 1'b1, GET, 3'd4, 4'd3, 32'h80, 64'd0);
        step;
        drive_a(1, 1'b0, GET, 3'd4, 4'd3, 32'h80, 64'd0);
        in0_if.d_ready = 1'b0;
        drive_d(1'b1, ACK_DATA, 3'd4, 5'h13, 64'hAA);
        settle;
        chk("t6_in1_d_valid", 64'(in1_if.d_valid), 64'd1);
        chk("t6_in0_d_valid", 64'(in0_if.d_valid), 64'd0);
        chk("t6_in1_d_src", 64'(in1_if.d_source), 64'h3);
        chk("t6_in1_d_data", in1_if.d_data, 64'hAA);
        chk("t6_out_d_ready", 64'(out_if.d_ready), 64'd1);
        step;
        drive_d(1'b1, ACK_DATA, 3'd4, 5'h13, 64'hBB);
        drive_a(1, 1'b1, GET, 3'd3, 4'd5, 32'h90, 64'd0);
        settle;
        chk("t6_inflight_b1", 64'(dut.inflight1), 64'd1);
        chk("t6_in1_d_valid_b2", 64'(in1_if.d_valid), 64'd1);
        chk("t6_in1_a_rdy", 64'(in1_if.a_ready), 64'd1);
        step;
        drive_a(1, 1'b0, GET, 3'd3, 4'd5, 32'h90, 64'd0);
        drive_d(1'b1, ACK, 3'd3, 5'h13, 64'd0);
        in1_if.d_ready = 1'b0;
        in0_if.d_ready = 1'b1;
        settle;
        chk("t6_inflight_same", 64'(dut.inflight1), 64'd1);
        chk("t6_out_d_ready_bp", 64'(out_if.d_ready), 64'd0);
        step;
        clear_all;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
